// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Instruction fetch front-end. A program counter drives one outstanding
//   read at a time to instruction memory (req/ack). Returned words are
//   buffered in a show-ahead prefetch FIFO and popped by the core with
//   read_fifo. A taken branch flushes the FIFO and any in-flight fetch,
//   then fetching restarts at branch_address.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   imem_req/imem_addr   fetch request, held with a stable address until ack
//   imem_ack/imem_rdata  one-cycle acknowledge with the fetched word
//   read_fifo            core pops the head entry
//   fifo_empty           no valid head entry
//   instruction_fetch    head entry, 0 (NOOP) when empty
//   branch_valid/_address taken-branch redirect
//   fifo_count           number of valid entries
//
// Optional build macro FETCH_STATS_EN adds stat_fetch_cnt (accepted pushes)
// and stat_discard_cnt (dropped acks), both 16-bit saturating counters.
module instr_fetch_queue #(
  parameter int unsigned         ADDR_W   = 11,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         DEPTH    = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        resetn,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ack,
  input  logic [DATA_W-1:0]           imem_rdata,
  input  logic                        read_fifo,
  output logic                        fifo_empty,
  output logic [DATA_W-1:0]           instruction_fetch,
  input  logic                        branch_valid,
  input  logic [ADDR_W-1:0]           branch_address,
  output logic [$clog2(DEPTH):0]      fifo_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]                 stat_fetch_cnt,
  output logic [15:0]                 stat_discard_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic                push_ok;
  logic                pop_ok;
  logic                has_space;

  // Branch outranks both push and pop; a pop on an empty FIFO is ignored.
  always_comb begin
    pop_ok    = read_fifo && (count != '0) && !branch_valid;
    push_ok   = (state == S_WAIT) && imem_ack && !branch_valid;
    // A new request is only issued when its slot is guaranteed, so the
    // eventual push can never overflow.
    has_space = (count != CW'(DEPTH)) || pop_ok;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (branch_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (branch_valid) begin
            pc <= branch_address;
          end else if (has_space) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (branch_valid) begin
            pc <= branch_address;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end else begin
              state <= S_DISCARD;
            end
          end else if (imem_ack) begin
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          // The stale request stays on the bus until memory answers it.
          if (branch_valid) pc <= branch_address;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push_ok) mem[wr_ptr] <= imem_rdata;
  end

  always_comb begin
    fifo_empty        = (count == '0);
    fifo_count        = count;
    instruction_fetch = fifo_empty ? '0 : mem[rd_ptr];
  end

`ifdef FETCH_STATS_EN
  logic discard_ev;

  always_comb begin
    discard_ev = imem_ack &&
                 ((state == S_DISCARD) || ((state == S_WAIT) && branch_valid));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_fetch_cnt   <= '0;
      stat_discard_cnt <= '0;
    end else begin
      if (push_ok && (stat_fetch_cnt != '1))
        stat_fetch_cnt <= stat_fetch_cnt + 16'd1;
      if (discard_ev && (stat_discard_cnt != '1))
        stat_discard_cnt <= stat_discard_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam logic [AW-1:0] RPC = 11'h000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          imem_req, imem_ack, read_fifo, fifo_empty, branch_valid;
  logic [AW-1:0] imem_addr, branch_address;
  logic [DW-1:0] imem_rdata, instruction_fetch;
  logic [3:0]    fifo_count;

  logic          w_req, w_ack, w_empty, w_pop, w_br;
  logic [AW-1:0] w_addr, w_ba;
  logic [DW-1:0] w_rdata, w_instr;
  logic [3:0]    w_count;

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetch_cnt, stat_discard_cnt;
  logic [15:0] w_sf, w_sd;
`endif

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .read_fifo(read_fifo), .fifo_empty(fifo_empty), .instruction_fetch(instruction_fetch),
    .branch_valid(branch_valid), .branch_address(branch_address), .fifo_count(fifo_count)
`ifdef FETCH_STATS_EN
    , .stat_fetch_cnt(stat_fetch_cnt), .stat_discard_cnt(stat_discard_cnt)
`endif
  );

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(11'h7FE)) u_wrap (
    .clk(clk), .resetn(resetn),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .read_fifo(w_pop), .fifo_empty(w_empty), .instruction_fetch(w_instr),
    .branch_valid(w_br), .branch_address(w_ba), .fifo_count(w_count)
`ifdef FETCH_STATS_EN
    , .stat_fetch_cnt(w_sf), .stat_discard_cnt(w_sd)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: queue of buffered words plus the state of
  // the single outstanding request (0 none, 1 live, 2 stale/abandoned).
  logic [DW-1:0] mq[$];
  logic [AW-1:0] m_pc, m_addr;
  int            m_pend;
  int unsigned   m_fetch, m_disc;

  // Stimulus controls
  bit            c_rst, c_br, c_pop, c_autopop, c_mem_en, c_force_ack;
  logic [AW-1:0] c_ba;
  int            ack_delay, wcnt;
  logic [DW-1:0] popped[$];
  logic [AW-1:0] wrap_seen[4];
  int            wrap_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat16(input int unsigned v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_step();
    if (!c_rst) begin
      mq.delete();
      m_pc = RPC; m_addr = RPC; m_pend = 0; m_fetch = 0; m_disc = 0;
    end else if (c_br) begin
      if (m_pend != 0 && imem_ack) m_disc = sat16(m_disc);
      if (m_pend != 0) m_pend = imem_ack ? 0 : 2;
      mq.delete();
      m_pc = c_ba;
    end else begin
      if (read_fifo && mq.size() > 0) void'(mq.pop_front());
      case (m_pend)
        1: if (imem_ack) begin
             mq.push_back(32'hA000_0000 | 32'(m_addr));
             m_pc = m_pc + 1'b1;
             m_pend = 0;
             m_fetch = sat16(m_fetch);
           end
        2: if (imem_ack) begin
             m_pend = 0;
             m_disc = sat16(m_disc);
           end
        default: if (mq.size() < DEPTH) begin
             m_pend = 1;
             m_addr = m_pc;
           end
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    resetn         = c_rst;
    branch_valid   = c_br;
    branch_address = c_ba;
    read_fifo      = c_autopop ? (fifo_empty === 1'b0) : c_pop;
    if (c_force_ack) begin
      imem_ack = 1'b1; wcnt = 0;
    end else if (c_mem_en && imem_req === 1'b1) begin
      if (wcnt >= ack_delay) begin imem_ack = 1'b1; wcnt = 0; end
      else begin imem_ack = 1'b0; wcnt++; end
    end else begin
      imem_ack = 1'b0; wcnt = 0;
    end
    imem_rdata = 32'hA000_0000 | 32'(imem_addr);
    w_ack   = (w_req === 1'b1);
    w_rdata = 32'(w_addr);
    if (w_ack && c_rst && wrap_n < 4) begin
      wrap_seen[wrap_n] = w_addr;
      wrap_n++;
    end
    if (read_fifo && fifo_empty === 1'b0) popped.push_back(instruction_fetch);
    model_step();
    @(posedge clk);
    #1;
    check("req",   64'(imem_req), 64'(m_pend != 0));
    check("addr",  64'(imem_addr), 64'(m_addr));
    check("count", 64'(fifo_count), 64'(mq.size()));
    check("empty", 64'(fifo_empty), 64'(mq.size() == 0));
    check("instr", 64'(instruction_fetch), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
`ifdef FETCH_STATS_EN
    check("stat_fetch",   64'(stat_fetch_cnt),   64'(m_fetch));
    check("stat_discard", 64'(stat_discard_cnt), 64'(m_disc));
`endif
  endtask

  typedef struct {
    bit            rst, br;
    logic [AW-1:0] ba;
    bit            pop, ack;
    bit            req;
    logic [AW-1:0] addr;
    int            cnt;
    logic [DW-1:0] instr;
  } vec_t;

  vec_t tv[13];

  initial begin
    int guard;
    // rst br ba pop ack | req addr cnt instr
    tv[0]  = '{0, 0, 11'h000, 0, 0, 0, 11'h000, 0, 32'h0};
    tv[1]  = '{1, 0, 11'h000, 0, 0, 1, 11'h000, 0, 32'h0};
    tv[2]  = '{1, 0, 11'h000, 0, 1, 0, 11'h000, 1, 32'hA000_0000};
    tv[3]  = '{1, 0, 11'h000, 0, 0, 1, 11'h001, 1, 32'hA000_0000};
    tv[4]  = '{1, 0, 11'h000, 0, 1, 0, 11'h001, 2, 32'hA000_0000};
    tv[5]  = '{1, 0, 11'h000, 1, 0, 1, 11'h002, 1, 32'hA000_0001};
    tv[6]  = '{1, 1, 11'h155, 1, 1, 0, 11'h002, 0, 32'h0};
    tv[7]  = '{1, 0, 11'h000, 0, 0, 1, 11'h155, 0, 32'h0};
    tv[8]  = '{1, 1, 11'h020, 0, 0, 1, 11'h155, 0, 32'h0};
    tv[9]  = '{1, 1, 11'h030, 0, 0, 1, 11'h155, 0, 32'h0};
    tv[10] = '{1, 0, 11'h000, 0, 1, 0, 11'h155, 0, 32'h0};
    tv[11] = '{1, 0, 11'h000, 0, 0, 1, 11'h030, 0, 32'h0};
    tv[12] = '{1, 0, 11'h000, 0, 1, 0, 11'h030, 1, 32'hA000_0030};

    resetn = 1'b0; branch_valid = 1'b0; branch_address = '0; read_fifo = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    w_ack = 1'b0; w_rdata = '0; w_pop = 1'b0; w_br = 1'b0; w_ba = '0;
    c_rst = 0; c_br = 0; c_ba = '0; c_pop = 0; c_autopop = 0; c_mem_en = 0; c_force_ack = 0;
    ack_delay = 0; wcnt = 0; wrap_n = 0;

    // Directed table: handshake, pop, branch+ack+pop, branch into DISCARD
    foreach (tv[i]) begin
      c_rst = tv[i].rst; c_br = tv[i].br; c_ba = tv[i].ba;
      c_pop = tv[i].pop; c_force_ack = tv[i].ack;
      cycle();
      check($sformatf("tv%0d_req", i),   64'(imem_req),          64'(tv[i].req));
      check($sformatf("tv%0d_addr", i),  64'(imem_addr),         64'(tv[i].addr));
      check($sformatf("tv%0d_cnt", i),   64'(fifo_count),        64'(tv[i].cnt));
      check($sformatf("tv%0d_empty", i), 64'(fifo_empty),        64'(tv[i].cnt == 0));
      check($sformatf("tv%0d_instr", i), 64'(instruction_fetch), 64'(tv[i].instr));
    end
    c_br = 0; c_pop = 0; c_force_ack = 0;

    // Fill without popping: stops at DEPTH and holds word@0 at the head
    c_rst = 0; cycle(); c_rst = 1;
    c_mem_en = 1; ack_delay = 1;
    for (int i = 0; i < 40; i++) cycle();
    check("fill_count", 64'(fifo_count), 64'd8);
    check("fill_req",   64'(imem_req), 64'd0);
    check("fill_head",  64'(instruction_fetch), 64'hA000_0000);

    // Continuous pop: words arrive in order, no gaps or duplicates
    c_rst = 0; cycle(); c_rst = 1;
    ack_delay = 0; c_autopop = 1; popped.delete();
    for (int i = 0; i < 60; i++) begin
      cycle();
      check("stream_le1", 64'(fifo_count <= 1), 64'd1);
    end
    c_autopop = 0;
    check("stream_len", 64'(popped.size() >= 15), 64'd1);
    foreach (popped[i]) check("stream_word", 64'(popped[i]), 64'(32'hA000_0000 | i));

    // Branch while WAIT with slow memory: stale word dropped, refetch at 0x155
    c_rst = 0; cycle(); c_rst = 1;
    ack_delay = 3; guard = 0;
    while (!(mq.size() == 2 && m_pend == 1) && guard < 40) begin cycle(); guard++; end
    check("br_setup", 64'(guard < 40), 64'd1);
    c_br = 1; c_ba = 11'h155; cycle(); c_br = 0;
    check("br_empty", 64'(fifo_empty), 64'd1);
    check("br_instr", 64'(instruction_fetch), 64'd0);
    guard = 0;
    while (!(m_pend == 1 && m_addr == 11'h155) && guard < 20) begin cycle(); guard++; end
    check("br_refetch_bound", 64'(guard < 20), 64'd1);
    check("br_refetch_addr", 64'(imem_addr), 64'h155);
`ifdef FETCH_STATS_EN
    check("br_discard_cnt", 64'(stat_discard_cnt), 64'd1);
`endif

    // Reset mid-WAIT with 5 entries, then a late ack that must be ignored
    c_rst = 0; cycle(); c_rst = 1;
    ack_delay = 0; guard = 0;
    while (!(mq.size() == 5 && m_pend == 1) && guard < 40) begin cycle(); guard++; end
    check("rst_setup", 64'(guard < 40), 64'd1);
    c_rst = 0; cycle(); c_rst = 1;
    check("rst_req",   64'(imem_req), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_instr", 64'(instruction_fetch), 64'd0);
    c_mem_en = 0; c_force_ack = 1; cycle(); c_force_ack = 0;
    check("late_ack_count", 64'(fifo_count), 64'd0);
    check("late_ack_addr",  64'(imem_addr), 64'(RPC));
    c_mem_en = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("restart_head", 64'(instruction_fetch), 64'hA000_0000);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      c_rst       = ($urandom_range(0, 299) != 0);
      c_br        = ($urandom_range(0, 19) == 0);
      c_ba        = AW'($urandom);
      c_pop       = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c_force_ack = ($urandom_range(0, 29) == 0);
      if (wcnt == 0) ack_delay = $urandom_range(0, 3);
      cycle();
    end
    c_rst = 1; c_br = 0; c_pop = 0; c_force_ack = 0;

    // RESET_PC=0x7FE instance wraps the PC modulo 2^ADDR_W
    check("wrap_n",  64'(wrap_n), 64'd4);
    check("wrap_a0", 64'(wrap_seen[0]), 64'h7FE);
    check("wrap_a1", 64'(wrap_seen[1]), 64'h7FF);
    check("wrap_a2", 64'(wrap_seen[2]), 64'h000);
    check("wrap_a3", 64'(wrap_seen[3]), 64'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
